wrq: RTL and testbench

//  Write-request scheduler; counterpart of the read-request queue arbiter (rrq).
//  rrq picks a non-empty app data queue to drain toward the host. wrq collects

---
 rtl/rah_pkg.sv | 14 +
 rtl/wrq_rr_pick.sv | 37 +++
 rtl/wrq.sv | 130 +++++++++++++
 tb/tb_wrq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rah_pkg.sv
// Shared types and defaults for the host/app request schedulers (wrq, and rrq later).
// The FSM state encoding and the default sizing both live here.
package rah_pkg;

  localparam int TOTAL_APPS_DEF   = 8;
  localparam int APP_ID_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/wrq_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of req at or after
// start, wrapping modulo N.
module rr_pick
  import rah_pkg::*;
#(
  parameter int N = TOTAL_APPS_DEF,
  parameter int W = APP_ID_WIDTH_DEF
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] index
);

  logic [W:0]   pos;
  logic [W-1:0] idx;

  // Walk from the farthest offset down to offset 0 so the nearest hit overwrites.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, start} + (W+1)'(i);
      if (pos >= (W+1)'(N)) begin
        pos = pos - (W+1)'(N);
      end
      idx = pos[W-1:0];
      if (req[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/wrq.sv
// Write-request scheduler: collects host write requests into a pending bitmap and
// grants one app at a time, round-robin, holding until write_done or a watchdog abort.
module wrq
  import rah_pkg::*;
#(
  parameter int TOTAL_APPS     = TOTAL_APPS_DEF,
  parameter int APP_ID_WIDTH   = APP_ID_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_req_valid,
  input  logic [APP_ID_WIDTH-1:0] wr_req_app_id,
  output logic                    wr_req_ready,
  input  logic [TOTAL_APPS-1:0]   data_queue_full,
  input  logic                    is_busy,
  input  logic                    write_done,
  output logic                    write_queue,
  output logic [APP_ID_WIDTH-1:0] app_id,
  output logic [TOTAL_APPS-1:0]   pending,
  output logic                    timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [APP_ID_WIDTH-1:0] LAST_ID = APP_ID_WIDTH'(TOTAL_APPS - 1);

  state_e                  state_q, state_d;
  logic [TOTAL_APPS-1:0]   pending_q, pending_d;
  logic [APP_ID_WIDTH-1:0] app_id_q, app_id_d;
  logic [APP_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    write_queue_q, write_queue_d;
  logic                    timeout_err_q, timeout_err_d;

  logic [TOTAL_APPS-1:0]   set_vec, clr_vec, eligible;
  logic [APP_ID_WIDTH-1:0] start_ptr, pick_idx;
  logic                    pick_found, id_in_range, accept;
  logic                    done_hit, timeout_hit, release_hit;

  assign id_in_range  = 32'(wr_req_app_id) < TOTAL_APPS;
  assign wr_req_ready = id_in_range && !pending_q[wr_req_app_id];
  assign accept       = wr_req_valid && wr_req_ready;

  assign done_hit    = (state_q == WAIT) && write_done;
  assign timeout_hit = (state_q == WAIT) && !write_done && (TIMEOUT_CYCLES != 0) &&
                       (cnt_q == CNT_LAST);
  assign release_hit = done_hit || timeout_hit;

  // Set and clear are independent per bit; set is applied last so it wins.
  for (genvar gi = 0; gi < TOTAL_APPS; gi++) begin : g_bits
    assign set_vec[gi] = accept && (wr_req_app_id == APP_ID_WIDTH'(gi));
    assign clr_vec[gi] = release_hit && (app_id_q == APP_ID_WIDTH'(gi));
  end

  assign eligible  = pending_q & ~data_queue_full;
  assign start_ptr = (rr_ptr_q >= LAST_ID) ? '0 : rr_ptr_q + APP_ID_WIDTH'(1);

  rr_pick #(
    .N (TOTAL_APPS),
    .W (APP_ID_WIDTH)
  ) u_pick (
    .req   (eligible),
    .start (start_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    pending_d     = (pending_q & ~clr_vec) | set_vec;
    app_id_d      = app_id_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    write_queue_d = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found && !is_busy) begin
          state_d       = GRANT;
          app_id_d      = pick_idx;
          rr_ptr_d      = pick_idx;
          write_queue_d = 1'b1;
        end
      end
      GRANT: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (done_hit) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      app_id_q      <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      write_queue_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      app_id_q      <= app_id_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      write_queue_q <= write_queue_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign write_queue = write_queue_q;
  assign app_id      = app_id_q;
  assign pending     = pending_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_wrq.sv
// Directed bench for wrq: each task drives one scenario and checks its outputs inline.
module tb_wrq;

  localparam int N  = 8;
  localparam int W  = 3;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_req_valid;
  logic [W-1:0] wr_req_app_id;
  logic         wr_req_ready;
  logic [N-1:0] data_queue_full;
  logic         is_busy;
  logic         write_done;
  logic         write_queue;
  logic [W-1:0] app_id;
  logic [N-1:0] pending;
  logic         timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  wrq #(
    .TOTAL_APPS     (N),
    .APP_ID_WIDTH   (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_req_valid    (wr_req_valid),
    .wr_req_app_id   (wr_req_app_id),
    .wr_req_ready    (wr_req_ready),
    .data_queue_full (data_queue_full),
    .is_busy         (is_busy),
    .write_done      (write_done),
    .write_queue     (write_queue),
    .app_id          (app_id),
    .pending         (pending),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_req_valid = 1'b0; wr_req_app_id = '0;
    data_queue_full = '0; is_busy = 1'b0; write_done = 1'b0;
    step(); step();
    n_cmp++; if (write_queue !== 1'b0) begin n_bad++; $display("FAIL reset_wq: got %0b expected 0", write_queue); end
    n_cmp++; if (app_id !== 3'd0) begin n_bad++; $display("FAIL reset_app_id: got %0d expected 0", app_id); end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL reset_pending: got %0h expected 00", pending); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b expected 0", timeout_err); end
    rst = 1'b0;
    #1;
    n_cmp++; if (wr_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b expected 1", wr_req_ready); end
    $display("reset done");
  endtask

  task automatic test_single_grant();
    wr_req_valid = 1'b1; wr_req_app_id = 3'd3;
    #1;
    n_cmp++; if (wr_req_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %0b expected 1", wr_req_ready); end
    step(); wr_req_valid = 1'b0;
    n_cmp++; if (pending !== 8'h08) begin n_bad++; $display("FAIL single_pending: got %0h expected 08", pending); end
    n_cmp++; if (write_queue !== 1'b0) begin n_bad++; $display("FAIL single_wq_early: got %0b expected 0", write_queue); end
    step();
    n_cmp++; if (write_queue !== 1'b1) begin n_bad++; $display("FAIL single_wq: got %0b expected 1", write_queue); end
    n_cmp++; if (app_id !== 3'd3) begin n_bad++; $display("FAIL single_app_id: got %0d expected 3", app_id); end
    step();
    #1;
    n_cmp++; if (write_queue !== 1'b0) begin n_bad++; $display("FAIL single_wq_pulse: got %0b expected 0", write_queue); end
    n_cmp++; if (wr_req_ready !== 1'b0) begin n_bad++; $display("FAIL single_dup_ready: got %0b expected 0", wr_req_ready); end
    write_done = 1'b1;
    step(); write_done = 1'b0;
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL single_pending_clr: got %0h expected 00", pending); end
    step();
    n_cmp++; if (write_queue !== 1'b0) begin n_bad++; $display("FAIL single_no_regrant: got %0b expected 0", write_queue); end
    $display("single grant app 3 done");
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_id [3];
    logic [N-1:0] exp_pend [3];
    exp_id   = '{3'd5, 3'd1, 3'd2};
    exp_pend = '{8'h06, 8'h04, 8'h00};
    // Serve app 2 first so the pointer sits at 2.
    wr_req_valid = 1'b1; wr_req_app_id = 3'd2;
    step(); wr_req_valid = 1'b0;
    step();
    n_cmp++; if (write_queue !== 1'b1 || app_id !== 3'd2) begin n_bad++; $display("FAIL rr_warmup: got wq=%0b id=%0d expected wq=1 id=2", write_queue, app_id); end
    step(); write_done = 1'b1;
    step(); write_done = 1'b0;
    is_busy = 1'b1;
    wr_req_valid = 1'b1; wr_req_app_id = 3'd1; step();
    wr_req_app_id = 3'd5; step();
    wr_req_app_id = 3'd2; step();
    wr_req_valid = 1'b0;
    n_cmp++; if (pending !== 8'h26) begin n_bad++; $display("FAIL rr_pending: got %0h expected 26", pending); end
    step();
    n_cmp++; if (write_queue !== 1'b0) begin n_bad++; $display("FAIL rr_busy_hold: got %0b expected 0", write_queue); end
    is_busy = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (write_queue !== 1'b1 || app_id !== exp_id[k]) begin n_bad++; $display("FAIL rr_grant%0d: got wq=%0b id=%0d expected wq=1 id=%0d", k, write_queue, app_id, exp_id[k]); end
      $display("rr grant app %0d", app_id);
      step(); step();
      n_cmp++; if (write_queue !== 1'b0) begin n_bad++; $display("FAIL rr_wait%0d: got %0b expected 0", k, write_queue); end
      write_done = 1'b1;
      step(); write_done = 1'b0;
      n_cmp++; if (write_queue !== 1'b0) begin n_bad++; $display("FAIL rr_gap%0d: got %0b expected 0", k, write_queue); end
      n_cmp++; if (pending !== exp_pend[k]) begin n_bad++; $display("FAIL rr_pend%0d: got %0h expected %0h", k, pending, exp_pend[k]); end
      if (k < 2) step();
    end
  endtask

  task automatic test_queue_full();
    data_queue_full = 8'h10;
    wr_req_valid = 1'b1; wr_req_app_id = 3'd4;
    step(); wr_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (write_queue !== 1'b0 || pending !== 8'h10) begin n_bad++; $display("FAIL full_hold%0d: got wq=%0b pend=%0h expected wq=0 pend=10", i, write_queue, pending); end
    end
    data_queue_full = 8'h00;
    step();
    n_cmp++; if (write_queue !== 1'b1 || app_id !== 3'd4) begin n_bad++; $display("FAIL full_release: got wq=%0b id=%0d expected wq=1 id=4", write_queue, app_id); end
    $display("full release grant app %0d", app_id);
    data_queue_full = 8'h10;
    step(); write_done = 1'b1;
    step(); write_done = 1'b0; data_queue_full = 8'h00;
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL full_pending_clr: got %0h expected 00", pending); end
  endtask

  task automatic test_timeout();
    int early;
    wr_req_valid = 1'b1; wr_req_app_id = 3'd0;
    step(); wr_req_valid = 1'b0;
    step();
    n_cmp++; if (write_queue !== 1'b1 || app_id !== 3'd0) begin n_bad++; $display("FAIL to_grant: got wq=%0b id=%0d expected wq=1 id=0", write_queue, app_id); end
    early = 0;
    for (int i = 1; i <= TO; i++) begin
      step();
      if (timeout_err !== 1'b0) early++;
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL to_early: got %0d pulses expected 0", early); end
    n_cmp++; if (pending !== 8'h01) begin n_bad++; $display("FAIL to_pend_hold: got %0h expected 01", pending); end
    step();
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %0b expected 1", timeout_err); end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL to_pend_clr: got %0h expected 00", pending); end
    step();
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_err_pulse: got %0b expected 0", timeout_err); end
    $display("timeout abort app 0");
    // Done arriving on the last watchdog cycle must suppress the abort.
    wr_req_valid = 1'b1; wr_req_app_id = 3'd0;
    step(); wr_req_valid = 1'b0;
    step();
    n_cmp++; if (write_queue !== 1'b1 || app_id !== 3'd0) begin n_bad++; $display("FAIL to_regrant: got wq=%0b id=%0d expected wq=1 id=0", write_queue, app_id); end
    for (int i = 1; i <= TO; i++) step();
    write_done = 1'b1;
    step(); write_done = 1'b0;
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_done_wins: got %0b expected 0", timeout_err); end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL to_done_pend: got %0h expected 00", pending); end
  endtask

  task automatic test_simultaneous();
    wr_req_valid = 1'b1; wr_req_app_id = 3'd2;
    step(); wr_req_valid = 1'b0;
    step();
    n_cmp++; if (write_queue !== 1'b1 || app_id !== 3'd2) begin n_bad++; $display("FAIL sim_grant2: got wq=%0b id=%0d expected wq=1 id=2", write_queue, app_id); end
    step();
    write_done = 1'b1; wr_req_valid = 1'b1; wr_req_app_id = 3'd6;
    #1;
    n_cmp++; if (wr_req_ready !== 1'b1) begin n_bad++; $display("FAIL sim_ready6: got %0b expected 1", wr_req_ready); end
    step(); write_done = 1'b0;
    #1;
    n_cmp++; if (pending !== 8'h40) begin n_bad++; $display("FAIL sim_pending: got %0h expected 40", pending); end
    n_cmp++; if (wr_req_ready !== 1'b0) begin n_bad++; $display("FAIL sim_dup_ready: got %0b expected 0", wr_req_ready); end
    step(); wr_req_valid = 1'b0;
    n_cmp++; if (write_queue !== 1'b1 || app_id !== 3'd6) begin n_bad++; $display("FAIL sim_grant6: got wq=%0b id=%0d expected wq=1 id=6", write_queue, app_id); end
    $display("simultaneous grant app %0d", app_id);
    step(); write_done = 1'b1;
    step(); write_done = 1'b0;
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL sim_pend_clr: got %0h expected 00", pending); end
  endtask

  task automatic test_reset_mid_wait();
    int spurious;
    wr_req_valid = 1'b1; wr_req_app_id = 3'd1;
    step(); wr_req_valid = 1'b0;
    step();
    n_cmp++; if (write_queue !== 1'b1 || app_id !== 3'd1) begin n_bad++; $display("FAIL rst_grant1: got wq=%0b id=%0d expected wq=1 id=1", write_queue, app_id); end
    step(); step();
    wr_req_valid = 1'b1; wr_req_app_id = 3'd3;
    step(); wr_req_valid = 1'b0;
    n_cmp++; if (pending !== 8'h0A) begin n_bad++; $display("FAIL rst_pend_pre: got %0h expected 0a", pending); end
    rst = 1'b1; write_done = 1'b1;
    step(); rst = 1'b0; write_done = 1'b0;
    n_cmp++; if (write_queue !== 1'b0 || app_id !== 3'd0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_outputs: got wq=%0b id=%0d err=%0b expected all 0", write_queue, app_id, timeout_err); end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL rst_pending: got %0h expected 00", pending); end
    spurious = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (write_queue !== 1'b0 || timeout_err !== 1'b0) spurious++;
    end
    n_cmp++; if (spurious !== 0) begin n_bad++; $display("FAIL rst_spurious: got %0d pulses expected 0", spurious); end
    $display("reset mid-wait done");
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_queue_full();
    test_timeout();
    test_simultaneous();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
